// File: rtl/serial_add4.sv
// serial_add4: bit-serial 4-bit adder computing A + B + Cin one bit per clock.
// A single full-adder slice and a carry flip-flop walk the operands LSB first
// under a start/busy/done handshake. Sum, Cout (and Ovf) are registered and
// only change when an operation completes.
// Optional feature: define ADD4_OVF_EN to add the Ovf port (two's-complement
// overflow registered at completion).
module serial_add4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic       busy,
    output logic       done,
    output logic [3:0] Sum,
`ifdef ADD4_OVF_EN
    output logic       Cout,
    output logic       Ovf
`else
    output logic       Cout
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] cnt;
    logic [3:0] a_shift;
    logic [3:0] b_shift;
    logic [3:0] psum;
    logic       carry;
    logic       slice_sum;
    logic       slice_carry;

    // Full-adder slice on the current operand LSBs and the stored carry.
    always_comb begin
        slice_sum   = a_shift[0] ^ b_shift[0] ^ carry;
        slice_carry = (a_shift[0] & b_shift[0]) | (a_shift[0] & carry) | (b_shift[0] & carry);
    end

    assign busy = (state == RUN);

    // Handshake FSM plus operand shifting, with results committed only on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            a_shift <= 4'h0;
            b_shift <= 4'h0;
            psum    <= 4'h0;
            carry   <= 1'b0;
            done    <= 1'b0;
            Sum     <= 4'h0;
            Cout    <= 1'b0;
`ifdef ADD4_OVF_EN
            Ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_shift <= A;
                        b_shift <= B;
                        carry   <= Cin;
                        cnt     <= 2'd0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_shift <= {1'b0, a_shift[3:1]};
                    b_shift <= {1'b0, b_shift[3:1]};
                    psum    <= {slice_sum, psum[3:1]};
                    carry   <= slice_carry;
                    cnt     <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        Sum   <= {slice_sum, psum[3:1]};
                        Cout  <= slice_carry;
`ifdef ADD4_OVF_EN
                        // The carry register still holds the carry into bit 3 here.
                        Ovf   <= carry ^ slice_carry;
`endif
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
